// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched instruction into an ALU micro-op, owns the register file,
// counts decoded instructions and tracks HALT. Define DECODE_WB_BYPASS_EN for write-before-read.
//
// state      | meaning
// ST_RUN     | decoding normally
// ST_HALTED  | HALT seen; every instruction is a bubble until rst

module decode_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       curr_instr,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [2:0]        ex_op,
    output logic [3:0]        ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic              ex_we,
    output logic              illegal,
    output logic              halt,
    output logic [CNT_W-1:0]  decode_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rf_q [NREGS];
    logic                ex_valid_q, ex_valid_d;
    logic [2:0]          ex_op_q, ex_op_d;
    logic [3:0]          ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0]   ex_a_q, ex_a_d;
    logic [DATA_W-1:0]   ex_b_q, ex_b_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [3:0]          op, rd, rs1, rs2;
    logic [DATA_W-1:0]   rs1_val, rs2_val;

    assign op  = curr_instr[15:12];
    assign rd  = curr_instr[11:8];
    assign rs1 = curr_instr[7:4];
    assign rs2 = curr_instr[3:0];

    always_comb begin
        rs1_val = (rs1 == 4'd0) ? '0 : rf_q[rs1];
        rs2_val = (rs2 == 4'd0) ? '0 : rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
        // forward the write landing at this edge so a dependent instruction needs no gap
        if (wb_en && (wb_addr != 4'd0) && (wb_addr == rs1)) rs1_val = wb_data;
        if (wb_en && (wb_addr != 4'd0) && (wb_addr == rs2)) rs2_val = wb_data;
`endif
    end

    always_comb begin
        state_d    = state_q;
        ex_valid_d = 1'b0;
        ex_op_d    = 3'd0;
        ex_rd_d    = 4'd0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        illegal_d  = 1'b0;
        cnt_d      = cnt_q;
        if (state_q == ST_RUN) begin
            case (op)
                4'd0: ;
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                    ex_valid_d = 1'b1;
                    ex_op_d    = op[2:0];
                    ex_rd_d    = rd;
                    ex_a_d     = rs1_val;
                    ex_b_d     = rs2_val;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
                4'd6: begin
                    ex_valid_d = 1'b1;
                    ex_rd_d    = rd;
                    ex_b_d     = DATA_W'(curr_instr[7:0]);
                    cnt_d      = cnt_q + CNT_W'(1);
                end
                4'd15: state_d = ST_HALTED;
                default: illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
            ex_op_q    <= 3'd0;
            ex_rd_q    <= 4'd0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
            // writes still land while halted so in-flight results drain
            if (wb_en && (wb_addr != 4'd0)) rf_q[wb_addr] <= wb_data;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_we        = ex_valid_q;
    assign ex_op        = ex_op_q;
    assign ex_rd        = ex_rd_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign illegal      = illegal_q;
    assign halt         = (state_q == ST_HALTED);
    assign decode_count = cnt_q;

endmodule
